// File: rtl/genius_datapath_param.sv
// Genius game datapath: move RAM, round/address counters, move and difficulty
// registers, button edge detector, level-scaled move timer, display timer, error counter.
module genius_datapath_param #(
  parameter int NBOT     = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int TMO_CYC  = 5000,
  parameter int SHOW_CYC = 2000,
  parameter int MAX_LVL  = 3,
  parameter int ERR_W    = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NBOT-1:0] botoes,
  input  logic            grava,
  input  logic            zeraR,
  input  logic            registraR,
  input  logic            zeraDif,
  input  logic            registraDif,
  input  logic            zeraCE,
  input  logic            contaCE,
  input  logic            zeraCR,
  input  logic            contaCR,
  input  logic            zeraT,
  input  logic            contaT,
  input  logic            zeraTI,
  input  logic            contaTI,
  input  logic            zeraErr,
  input  logic            contaErr,
  output logic            jogada_correta,
  output logic            enderecoIgualRodada,
  output logic            fimCE,
  output logic            fimCR,
  output logic            jogada_feita,
  output logic            timeout,
  output logic            timeout_jogada_inicial,
  output logic [NBOT-1:0] leds,
  output logic [1:0]      nivel,
  output logic [ERR_W-1:0] erros,
  output logic [AW-1:0]   db_contagem,
  output logic [AW-1:0]   db_rodada,
  output logic [NBOT-1:0] db_jogada,
  output logic [NBOT-1:0] db_memoria,
  output logic            db_tem_jogada
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int SW = $clog2(SHOW_CYC + 1);
  localparam logic [TW-1:0] TMO_V  = TW'(TMO_CYC);
  localparam logic [SW-1:0] SHOW_M1 = SW'(SHOW_CYC - 1);

  logic [AW-1:0]    ce_q, ce_d, cr_q, cr_d;
  logic [NBOT-1:0]  jog_q, jog_d, dif_q, dif_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [SW-1:0]    tmi_q, tmi_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             prev_q, prev_d;

  logic [NBOT-1:0]  mem [DEPTH];
  logic [AW-1:0]    rd_addr;
  logic [NBOT-1:0]  rd_data;
  logic [1:0]       nivel_c;
  logic [TW-1:0]    lim, lim_m1;
  logic             tem_jogada;

  assign tem_jogada = |botoes;
  assign rd_addr    = grava ? cr_q : ce_q;
  assign rd_data    = mem[rd_addr];

  always_ff @(posedge clock) begin
    if (grava) mem[cr_q] <= botoes;
  end

  // Lowest set bit wins; scanning from the top lets lower bits overwrite.
  always_comb begin
    nivel_c = '0;
    for (int i = NBOT - 1; i >= 0; i--) begin
      if (dif_q[i]) nivel_c = (i > MAX_LVL) ? 2'(MAX_LVL) : 2'(i);
    end
    lim = TMO_V >> nivel_c;
    if (lim == '0) lim = TW'(1);
    lim_m1 = lim - TW'(1);
  end

  always_comb begin
    ce_d   = ce_q;
    cr_d   = cr_q;
    jog_d  = jog_q;
    dif_d  = dif_q;
    tmr_d  = tmr_q;
    tmi_d  = tmi_q;
    err_d  = err_q;
    prev_d = tem_jogada;
    if (zeraCE) ce_d = '0;
    else if (contaCE) ce_d = ce_q + AW'(1);
    if (zeraCR) cr_d = '0;
    else if (contaCR) cr_d = cr_q + AW'(1);
    if (zeraR) jog_d = '0;
    else if (registraR) jog_d = botoes;
    if (zeraDif) dif_d = '0;
    else if (registraDif) dif_d = botoes;
    // A count left above a freshly shortened limit wraps instead of timing out.
    if (zeraT) tmr_d = '0;
    else if (contaT) tmr_d = (tmr_q >= lim_m1) ? '0 : tmr_q + TW'(1);
    if (zeraTI) tmi_d = '0;
    else if (contaTI) tmi_d = (tmi_q >= SHOW_M1) ? '0 : tmi_q + SW'(1);
    if (zeraErr) err_d = '0;
    else if (contaErr && (err_q != '1)) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ce_q   <= '0;
      cr_q   <= '0;
      jog_q  <= '0;
      dif_q  <= '0;
      tmr_q  <= '0;
      tmi_q  <= '0;
      err_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      cr_q   <= cr_d;
      jog_q  <= jog_d;
      dif_q  <= dif_d;
      tmr_q  <= tmr_d;
      tmi_q  <= tmi_d;
      err_q  <= err_d;
      prev_q <= prev_d;
    end
  end

  assign jogada_correta         = (rd_data == jog_q);
  assign enderecoIgualRodada    = (ce_q == cr_q);
  assign fimCE                  = (ce_q == AW'(DEPTH - 1));
  assign fimCR                  = (cr_q == AW'(DEPTH - 1));
  assign jogada_feita           = tem_jogada & ~prev_q & reset;
  assign timeout                = (tmr_q == lim_m1);
  assign timeout_jogada_inicial = (tmi_q == SHOW_M1);
  assign leds                   = contaTI ? rd_data : botoes;
  assign nivel                  = nivel_c;
  assign erros                  = err_q;
  assign db_contagem            = ce_q;
  assign db_rodada              = cr_q;
  assign db_jogada              = jog_q;
  assign db_memoria             = rd_data;
  assign db_tem_jogada          = tem_jogada;

endmodule

// File: tb/tb_genius_datapath_param.sv
// Bench for genius_datapath_param: directed test-plan phases with literal checks,
// then random stimulus, all outputs compared every cycle against a behavioural model.
module tb_genius_datapath_param;

  localparam int NBOT     = 4;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int TMO_CYC  = 5000;
  localparam int SHOW_CYC = 2000;
  localparam int MAX_LVL  = 3;
  localparam int ERR_W    = 3;

  logic clock = 1'b0;
  logic reset;
  logic [NBOT-1:0] botoes;
  logic grava, zeraR, registraR, zeraDif, registraDif, zeraCE, contaCE;
  logic zeraCR, contaCR, zeraT, contaT, zeraTI, contaTI, zeraErr, contaErr;
  logic jogada_correta, enderecoIgualRodada, fimCE, fimCR, jogada_feita;
  logic timeout, timeout_jogada_inicial;
  logic [NBOT-1:0] leds, db_jogada, db_memoria;
  logic [1:0] nivel;
  logic [ERR_W-1:0] erros;
  logic [AW-1:0] db_contagem, db_rodada;
  logic db_tem_jogada;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int jf_cnt  = 0;

  genius_datapath_param #(
    .NBOT(NBOT), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC), .SHOW_CYC(SHOW_CYC),
    .MAX_LVL(MAX_LVL), .ERR_W(ERR_W)
  ) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .grava(grava),
    .zeraR(zeraR), .registraR(registraR), .zeraDif(zeraDif), .registraDif(registraDif),
    .zeraCE(zeraCE), .contaCE(contaCE), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraT(zeraT), .contaT(contaT), .zeraTI(zeraTI), .contaTI(contaTI),
    .zeraErr(zeraErr), .contaErr(contaErr),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimCE(fimCE), .fimCR(fimCR), .jogada_feita(jogada_feita), .timeout(timeout),
    .timeout_jogada_inicial(timeout_jogada_inicial), .leds(leds), .nivel(nivel),
    .erros(erros), .db_contagem(db_contagem), .db_rodada(db_rodada),
    .db_jogada(db_jogada), .db_memoria(db_memoria), .db_tem_jogada(db_tem_jogada)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NBOT-1:0] m_mem [DEPTH];
  bit   m_known [DEPTH];
  int   m_ce, m_cr, m_t, m_ti, m_err;
  logic [NBOT-1:0] m_jog, m_dif;
  bit   m_prev;

  function automatic int f_lvl(logic [NBOT-1:0] d);
    for (int i = 0; i < NBOT; i++) if (d[i]) return (i > MAX_LVL) ? MAX_LVL : i;
    return 0;
  endfunction

  function automatic int f_lim(logic [NBOT-1:0] d);
    int l;
    l = TMO_CYC / (1 << f_lvl(d));
    return (l < 1) ? 1 : l;
  endfunction

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  always @(posedge clock) begin
    int l;
    l = f_lim(m_dif);
    if (grava) begin
      m_mem[m_cr]   = botoes;
      m_known[m_cr] = 1'b1;
    end
    if (!reset) begin
      m_ce = 0; m_cr = 0; m_t = 0; m_ti = 0; m_err = 0;
      m_jog = '0; m_dif = '0; m_prev = 1'b0;
    end else begin
      if (zeraCE) m_ce = 0; else if (contaCE) m_ce = (m_ce + 1) % DEPTH;
      if (zeraCR) m_cr = 0; else if (contaCR) m_cr = (m_cr + 1) % DEPTH;
      if (zeraR) m_jog = '0; else if (registraR) m_jog = botoes;
      if (zeraDif) m_dif = '0; else if (registraDif) m_dif = botoes;
      if (zeraT) m_t = 0; else if (contaT) m_t = (m_t >= l - 1) ? 0 : m_t + 1;
      if (zeraTI) m_ti = 0; else if (contaTI) m_ti = (m_ti >= SHOW_CYC - 1) ? 0 : m_ti + 1;
      if (zeraErr) m_err = 0; else if (contaErr && m_err < (1 << ERR_W) - 1) m_err = m_err + 1;
      m_prev = |botoes;
    end
  end

  // compare process: every cycle on the falling edge
  always @(negedge clock) begin
    int ra;
    if (jogada_feita) jf_cnt++;
    if (chk_on) begin
      ra = grava ? m_cr : m_ce;
      cmp("enderecoIgualRodada", 32'(enderecoIgualRodada), 32'(m_ce == m_cr));
      cmp("fimCE", 32'(fimCE), 32'(m_ce == DEPTH - 1));
      cmp("fimCR", 32'(fimCR), 32'(m_cr == DEPTH - 1));
      cmp("jogada_feita", 32'(jogada_feita), 32'(reset && (|botoes) && !m_prev));
      cmp("timeout", 32'(timeout), 32'(m_t == f_lim(m_dif) - 1));
      cmp("timeout_jogada_inicial", 32'(timeout_jogada_inicial), 32'(m_ti == SHOW_CYC - 1));
      cmp("nivel", 32'(nivel), 32'(f_lvl(m_dif)));
      cmp("erros", 32'(erros), 32'(m_err));
      cmp("db_contagem", 32'(db_contagem), 32'(m_ce));
      cmp("db_rodada", 32'(db_rodada), 32'(m_cr));
      cmp("db_jogada", 32'(db_jogada), 32'(m_jog));
      cmp("db_tem_jogada", 32'(db_tem_jogada), 32'(|botoes));
      if (!contaTI) cmp("leds_botoes", 32'(leds), 32'(botoes));
      if (m_known[ra]) begin
        cmp("db_memoria", 32'(db_memoria), 32'(m_mem[ra]));
        cmp("jogada_correta", 32'(jogada_correta), 32'(m_mem[ra] == m_jog));
        if (contaTI) cmp("leds_mem", 32'(leds), 32'(m_mem[ra]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    grava = 0; zeraR = 0; registraR = 0; zeraDif = 0; registraDif = 0;
    zeraCE = 0; contaCE = 0; zeraCR = 0; contaCR = 0; zeraT = 0; contaT = 0;
    zeraTI = 0; contaTI = 0; zeraErr = 0; contaErr = 0;
  endtask

  task automatic all_on();
    grava = 1; zeraR = 1; registraR = 1; zeraDif = 1; registraDif = 1;
    zeraCE = 1; contaCE = 1; zeraCR = 1; contaCR = 1; zeraT = 1; contaT = 1;
    zeraTI = 1; contaTI = 1; zeraErr = 1; contaErr = 1;
  endtask

  // run the move timer until timeout, return enabled edges taken
  task automatic run_tmo(output int n);
    n = 0;
    contaT = 1;
    #1;
    while (!timeout && n < 6000) begin
      tick();
      n++;
    end
    contaT = 0;
    if (n >= 6000) cmp("timeout_bound", 32'(n), 32'(0));
  endtask

  logic [NBOT-1:0] pat [3];
  int n, jf0;

  initial begin
    pat[0] = 4'b0001; pat[1] = 4'b0100; pat[2] = 4'b1000;
    idle();
    botoes = '0;
    reset = 0;
    tick(); tick();
    chk_on = 1'b1;

    // reset with every enable high and a button held
    all_on();
    botoes = 4'b1111;
    #1 cmp("jf_in_reset", 32'(jogada_feita), 32'(0));
    tick();
    idle();
    botoes = '0;
    reset = 1;
    #1;
    cmp("rst_rodada", 32'(db_rodada), 32'(0));
    cmp("rst_contagem", 32'(db_contagem), 32'(0));
    cmp("rst_erros", 32'(erros), 32'(0));
    cmp("rst_jogada", 32'(db_jogada), 32'(0));
    cmp("rst_nivel", 32'(nivel), 32'(0));

    // record three moves, then replay them
    for (int k = 0; k < 3; k++) begin
      botoes = pat[k]; grava = 1; contaCR = 1;
      tick();
    end
    idle(); botoes = '0;
    zeraCE = 1; tick(); zeraCE = 0;
    for (int k = 0; k < 3; k++) begin
      #1 cmp("replay", 32'(db_memoria), 32'(pat[k]));
      contaCE = 1; tick(); contaCE = 0;
    end
    zeraCE = 1; tick(); zeraCE = 0;
    contaCE = 1; tick(); contaCE = 0;
    botoes = 4'b0100; registraR = 1; tick(); registraR = 0; botoes = '0;
    #1 cmp("correta_hit", 32'(jogada_correta), 32'(1));
    botoes = 4'b0010; registraR = 1; tick(); registraR = 0; botoes = '0;
    #1 cmp("correta_miss", 32'(jogada_correta), 32'(0));
    contaCE = 1; tick(); tick(); contaCE = 0;
    #1 cmp("addr_eq_round", 32'(enderecoIgualRodada), 32'(1));

    // address counter wrap
    zeraCE = 1; tick(); zeraCE = 0;
    for (int i = 0; i < 16; i++) begin
      contaCE = 1; tick(); contaCE = 0;
    end
    #1 cmp("ce_wrap", 32'(db_contagem), 32'(0));

    // difficulty and move timer
    botoes = 4'b0100; registraDif = 1; tick(); registraDif = 0; botoes = '0;
    #1 cmp("nivel_2", 32'(nivel), 32'(2));
    zeraT = 1; tick(); zeraT = 0;
    run_tmo(n);
    cmp("tmo_lvl2", 32'(n), 32'(1249));
    contaT = 1; tick(); contaT = 0;
    #1 cmp("tmo_wrap", 32'(timeout), 32'(0));
    registraDif = 1; tick(); registraDif = 0;
    #1 cmp("nivel_0", 32'(nivel), 32'(0));
    zeraT = 1; tick(); zeraT = 0;
    run_tmo(n);
    cmp("tmo_lvl0", 32'(n), 32'(4999));

    // level rises while count is above the new limit
    zeraT = 1; tick(); zeraT = 0;
    contaT = 1;
    for (int i = 0; i < 2000; i++) tick();
    contaT = 0;
    botoes = 4'b1100; registraDif = 1; tick(); registraDif = 0; botoes = '0;
    #1 cmp("no_false_tmo", 32'(timeout), 32'(0));
    contaT = 1; tick(); contaT = 0;
    run_tmo(n);
    cmp("tmo_after_rise", 32'(n), 32'(1249));

    // sync clear mid-count beats the enable
    contaT = 1;
    for (int i = 0; i < 100; i++) tick();
    zeraT = 1; tick(); zeraT = 0; contaT = 0;
    run_tmo(n);
    cmp("tmo_after_clear", 32'(n), 32'(1249));

    // display timer
    zeraTI = 1; tick(); zeraTI = 0;
    n = 0;
    contaTI = 1;
    #1;
    while (!timeout_jogada_inicial && n < 3000) begin
      tick();
      n++;
    end
    contaTI = 0;
    cmp("show_tmo", 32'(n), 32'(SHOW_CYC - 1));

    // edge detector
    botoes = '0; tick();
    jf0 = jf_cnt;
    botoes = 4'b0010; repeat (5) tick();
    botoes = 4'b0011; repeat (3) tick();
    botoes = 4'b0000; repeat (2) tick();
    botoes = 4'b1000; repeat (3) tick();
    botoes = 4'b0000; repeat (2) tick();
    cmp("press_pulses", 32'(jf_cnt - jf0), 32'(2));
    botoes = 4'b0100; reset = 0;
    jf0 = jf_cnt;
    repeat (3) tick();
    cmp("no_pulse_in_reset", 32'(jf_cnt - jf0), 32'(0));
    reset = 1; botoes = '0; tick();

    // error counter saturation
    contaErr = 1;
    repeat (9) tick();
    cmp("err_sat", 32'(erros), 32'(7));
    zeraErr = 1; tick(); zeraErr = 0; contaErr = 0;
    cmp("err_clear", 32'(erros), 32'(0));

    // random phase
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) botoes = NBOT'($urandom);
      grava       = ($urandom_range(0, 3) == 0);
      zeraR       = ($urandom_range(0, 15) == 0);
      registraR   = ($urandom_range(0, 3) == 0);
      zeraDif     = ($urandom_range(0, 31) == 0);
      registraDif = ($urandom_range(0, 7) == 0);
      zeraCE      = ($urandom_range(0, 15) == 0);
      contaCE     = ($urandom_range(0, 1) == 0);
      zeraCR      = ($urandom_range(0, 15) == 0);
      contaCR     = ($urandom_range(0, 2) == 0);
      zeraT       = ($urandom_range(0, 299) == 0);
      contaT      = ($urandom_range(0, 3) != 0);
      zeraTI      = ($urandom_range(0, 299) == 0);
      contaTI     = ($urandom_range(0, 1) == 0);
      zeraErr     = ($urandom_range(0, 31) == 0);
      contaErr    = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
